// File: rtl/mm_host_bridge.sv
// Host front end for the Montgomery multiplier: owns the bridge BRAM,
// streams operands in, kicks the multiplier, streams the result back out.
module mm_host_bridge #(
    parameter int s        = 8,
    parameter int RES_BASE = 3 * s + 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [16:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [16:0] out_data_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        addr_err_o,
    output logic        mm_start_o,
    input  logic        mm_done_i,
    input  logic [31:0] mm_BRAM_addr_i,
    input  logic [16:0] mm_BRAM_din_i,
    input  logic        mm_BRAM_we_i,
    input  logic        mm_BRAM_en_i,
    output logic [16:0] mm_BRAM_dout_o
);
    localparam int DEPTH  = 4 * s + 1;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(3 * s);
    localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(s - 1);
    localparam logic [ADDR_W-1:0] RES_A  = ADDR_W'(RES_BASE);

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT,
        RD_ISSUE,
        RD_HOLD
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] load_cnt;
    logic [ADDR_W-1:0] load_d;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_d;
    logic              load_we;
    logic [ADDR_W-1:0] b_addr;
    logic              b_ok;
    logic [16:0]       mem [DEPTH];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= LOAD;
            load_cnt <= '0;
            rd_cnt   <= '0;
        end else begin
            state    <= state_d;
            load_cnt <= load_d;
            rd_cnt   <= rd_d;
        end
    end

    always_comb begin
        state_d     = state;
        load_d      = load_cnt;
        rd_d        = rd_cnt;
        in_ready_o  = 1'b0;
        mm_start_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = 1'b1;
        load_we     = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (in_valid_i) begin
                    load_we = 1'b1;
                    load_d  = load_cnt + 1'b1;
                    if (load_cnt == LAST_K) begin
                        state_d = START;
                        load_d  = '0;
                    end
                end
            end
            START: begin
                mm_start_o = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (mm_done_i) begin
                    state_d = RD_ISSUE;
                    rd_d    = '0;
                end
            end
            RD_ISSUE: state_d = RD_HOLD;
            RD_HOLD: begin
                out_valid_o = 1'b1;
                out_last_o  = (rd_cnt == LAST_J);
                if (out_ready_i) begin
                    if (rd_cnt == LAST_J) begin
                        state_d = LOAD;
                        rd_d    = '0;
                    end else begin
                        state_d = RD_ISSUE;
                        rd_d    = rd_cnt + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Upper address bits must be zero and the low bits inside the array.
    assign b_addr = mm_BRAM_addr_i[ADDR_W-1:0];
    assign b_ok   = (mm_BRAM_addr_i[31:ADDR_W] == '0)
                 && (int'(b_addr) < DEPTH);

    always_ff @(posedge clock_i) begin
        if (load_we) begin
            mem[load_cnt] <= in_data_i;
        end
        if (mm_BRAM_en_i && mm_BRAM_we_i && b_ok) begin
            mem[b_addr] <= mm_BRAM_din_i;
        end
    end

    // Port A read register doubles as the held output word.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_data_o <= '0;
        end else if (state == RD_ISSUE) begin
            out_data_o <= mem[RES_A + rd_cnt];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mm_BRAM_dout_o <= '0;
            addr_err_o     <= 1'b0;
        end else if (mm_BRAM_en_i) begin
            if (b_ok) begin
                mm_BRAM_dout_o <= mem[b_addr];
            end else begin
                mm_BRAM_dout_o <= '0;
                addr_err_o     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mm_host_bridge.sv
// Randomized bench for mm_host_bridge against a word-array model
// of the bridge BRAM and the load/start/readout sequence.
module tb_mm_host_bridge;
    localparam int S     = 8;
    localparam int RB    = 3 * S + 1;
    localparam int NW    = 3 * S + 1;
    localparam int DEPTH = 4 * S + 1;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [16:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [16:0] out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic        addr_err_o;
    logic        mm_start_o;
    logic        mm_done_i;
    logic [31:0] mm_BRAM_addr_i;
    logic [16:0] mm_BRAM_din_i;
    logic        mm_BRAM_we_i;
    logic        mm_BRAM_en_i;
    logic [16:0] mm_BRAM_dout_o;

    int          vecs = 0;
    int          errs = 0;
    logic [16:0] ref_mem [DEPTH];

    mm_host_bridge #(.s(S)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_last_o     (out_last_o),
        .busy_o         (busy_o),
        .addr_err_o     (addr_err_o),
        .mm_start_o     (mm_start_o),
        .mm_done_i      (mm_done_i),
        .mm_BRAM_addr_i (mm_BRAM_addr_i),
        .mm_BRAM_din_i  (mm_BRAM_din_i),
        .mm_BRAM_we_i   (mm_BRAM_we_i),
        .mm_BRAM_en_i   (mm_BRAM_en_i),
        .mm_BRAM_dout_o (mm_BRAM_dout_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_idle(input string name);
        vecs++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0
            || mm_start_o !== 1'b0) begin
            errs++;
            $display("FAIL %s rdy=%b val=%b busy=%b start=%b want 1/0/0/0",
                     name, in_ready_o, out_valid_o, busy_o, mm_start_o);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    // mode 0 random data, 1 words k+1; noise toggles done and reads addr 7
    task automatic load_words(input bit fixed, input bit noise);
        logic [16:0] w;
        for (int k = 0; k < NW; k++) begin
            w          = fixed ? 17'(k + 1) : 17'($urandom);
            in_valid_i = 1'b1;
            in_data_i  = w;
            if (noise) mm_done_i = (k < 20) ? 1'($urandom) : 1'b0;
            if (noise && k == 10) begin
                mm_BRAM_en_i   = 1'b1;
                mm_BRAM_addr_i = 32'd7;
            end
            vecs++;
            if (in_ready_o !== 1'b1 || mm_start_o !== 1'b0) begin
                errs++;
                $display("FAIL load_k%0d rdy=%b start=%b want 1/0",
                         k, in_ready_o, mm_start_o);
            end
            step();
            ref_mem[k] = w;
            if (noise && k == 10) begin
                mm_BRAM_en_i = 1'b0;
                vecs++;
                if (mm_BRAM_dout_o !== ref_mem[7]) begin
                    errs++;
                    $display("FAIL rd7_during_load got=%h want=%h",
                             mm_BRAM_dout_o, ref_mem[7]);
                end
            end
        end
        mm_done_i = 1'b0;
        vecs++;
        if (in_ready_o !== 1'b0 || mm_start_o !== 1'b1 || busy_o !== 1'b1) begin
            errs++;
            $display("FAIL start_pulse rdy=%b start=%b busy=%b want 0/1/1",
                     in_ready_o, mm_start_o, busy_o);
        end
        step();
        in_valid_i = 1'b0;
        vecs++;
        if (mm_start_o !== 1'b0 || in_ready_o !== 1'b0) begin
            errs++;
            $display("FAIL start_once start=%b rdy=%b want 0/0",
                     mm_start_o, in_ready_o);
        end
    endtask

    task automatic verify_mem();
        for (int k = 0; k < NW; k++) begin
            mm_BRAM_en_i   = 1'b1;
            mm_BRAM_addr_i = 32'(k);
            step();
            vecs++;
            if (mm_BRAM_dout_o !== ref_mem[k]) begin
                errs++;
                $display("FAIL bram_%0d got=%h want=%h",
                         k, mm_BRAM_dout_o, ref_mem[k]);
            end
        end
        mm_BRAM_en_i   = 1'b0;
        mm_BRAM_addr_i = 32'd3;
        step();
        vecs++;
        if (mm_BRAM_dout_o !== ref_mem[NW-1]) begin
            errs++;
            $display("FAIL dout_hold got=%h want=%h",
                     mm_BRAM_dout_o, ref_mem[NW-1]);
        end
    endtask

    task automatic mult_write(input bit fixed);
        logic [16:0] w;
        for (int j = 0; j < S; j++) begin
            w              = fixed ? 17'(17'h1ABC0 + j) : 17'($urandom);
            mm_BRAM_en_i   = 1'b1;
            mm_BRAM_we_i   = 1'b1;
            mm_BRAM_addr_i = 32'(RB + j);
            mm_BRAM_din_i  = w;
            step();
            ref_mem[RB+j] = w;
        end
        mm_BRAM_en_i = 1'b0;
        mm_BRAM_we_i = 1'b0;
    endtask

    task automatic pulse_done();
        step();
        vecs++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errs++;
            $display("FAIL wait_idle val=%b busy=%b want 0/1",
                     out_valid_o, busy_o);
        end
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        vecs++;
        if (out_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL done_lat1 val=%b want 0", out_valid_o);
        end
    endtask

    task automatic read_fixed();
        out_ready_i = 1'b1;
        step();
        for (int j = 0; j < S; j++) begin
            vecs++;
            if (out_valid_o !== 1'b1 || out_data_o !== ref_mem[RB+j]
                || out_last_o !== (j == S - 1)) begin
                errs++;
                $display("FAIL rd_fixed_%0d v=%b d=%h l=%b want 1/%h/%b",
                         j, out_valid_o, out_data_o, out_last_o,
                         ref_mem[RB+j], j == S - 1);
            end
            step();
            if (j < S - 1) begin
                vecs++;
                if (out_valid_o !== 1'b0) begin
                    errs++;
                    $display("FAIL rd_gap_%0d val=%b want 0", j, out_valid_o);
                end
                step();
            end
        end
        out_ready_i = 1'b0;
        check_idle("after_fixed_read");
    endtask

    task automatic read_random(input int stop_at);
        int idx;
        int cyc;
        bit held;
        idx  = 0;
        cyc  = 0;
        held = 1'b0;
        while (idx < stop_at && cyc < 300) begin
            out_ready_i = 1'($urandom);
            if (held) begin
                vecs++;
                if (out_valid_o !== 1'b1) begin
                    errs++;
                    $display("FAIL held_valid idx=%0d val=%b want 1",
                             idx, out_valid_o);
                end
            end
            held = 1'b0;
            if (out_valid_o === 1'b1) begin
                vecs++;
                if (out_data_o !== ref_mem[RB+idx]
                    || out_last_o !== (idx == S - 1)) begin
                    errs++;
                    $display("FAIL rd_rand_%0d d=%h l=%b want %h/%b",
                             idx, out_data_o, out_last_o,
                             ref_mem[RB+idx], idx == S - 1);
                end
                if (out_ready_i) idx++;
                else held = 1'b1;
            end
            step();
            cyc++;
        end
        out_ready_i = 1'b0;
        vecs++;
        if (idx != stop_at) begin
            errs++;
            $display("FAIL rd_timeout got=%0d want=%0d", idx, stop_at);
        end
    endtask

    task automatic test_reset();
        reset_i        = 1'b1;
        in_valid_i     = 1'b0;
        in_data_i      = '0;
        out_ready_i    = 1'b0;
        mm_done_i      = 1'b0;
        mm_BRAM_addr_i = '0;
        mm_BRAM_din_i  = '0;
        mm_BRAM_we_i   = 1'b0;
        mm_BRAM_en_i   = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        check_idle("reset_state");
        vecs++;
        if (out_data_o !== '0 || out_last_o !== 1'b0 || addr_err_o !== 1'b0
            || mm_BRAM_dout_o !== '0) begin
            errs++;
            $display("FAIL reset_regs d=%h l=%b err=%b dout=%h want 0",
                     out_data_o, out_last_o, addr_err_o, mm_BRAM_dout_o);
        end
    endtask

    task automatic test_basic();
        load_words(1'b1, 1'b0);
        verify_mem();
        mult_write(1'b1);
        pulse_done();
        read_fixed();
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 2; r++) begin
            load_words(1'b0, 1'b0);
            mult_write(1'b0);
            pulse_done();
            read_random(S);
            check_idle("after_bp_read");
        end
    endtask

    task automatic test_done_in_load();
        load_words(1'b0, 1'b1);
        verify_mem();
        mult_write(1'b0);
        pulse_done();
        read_random(S);
        check_idle("after_noise_read");
    endtask

    task automatic test_addr_err();
        vecs++;
        if (addr_err_o !== 1'b0) begin
            errs++;
            $display("FAIL err_clear got=%b want 0", addr_err_o);
        end
        mm_BRAM_en_i   = 1'b1;
        mm_BRAM_we_i   = 1'b1;
        mm_BRAM_din_i  = 17'h155AA;
        mm_BRAM_addr_i = 32'd33;
        step();
        vecs++;
        if (mm_BRAM_dout_o !== '0 || addr_err_o !== 1'b1) begin
            errs++;
            $display("FAIL oob33 dout=%h err=%b want 0/1",
                     mm_BRAM_dout_o, addr_err_o);
        end
        mm_BRAM_addr_i = 32'h0001_0003;
        step();
        vecs++;
        if (mm_BRAM_dout_o !== '0 || addr_err_o !== 1'b1) begin
            errs++;
            $display("FAIL oob_hi dout=%h err=%b want 0/1",
                     mm_BRAM_dout_o, addr_err_o);
        end
        mm_BRAM_we_i   = 1'b0;
        mm_BRAM_addr_i = 32'd3;
        step();
        mm_BRAM_en_i = 1'b0;
        vecs++;
        if (mm_BRAM_dout_o !== ref_mem[3] || addr_err_o !== 1'b1) begin
            errs++;
            $display("FAIL addr3_kept dout=%h err=%b want %h/1",
                     mm_BRAM_dout_o, addr_err_o, ref_mem[3]);
        end
    endtask

    task automatic test_reset_wait();
        load_words(1'b0, 1'b0);
        vecs++;
        if (addr_err_o !== 1'b1) begin
            errs++;
            $display("FAIL err_sticky got=%b want 1", addr_err_o);
        end
        do_reset();
        check_idle("reset_in_wait");
        vecs++;
        if (addr_err_o !== 1'b0) begin
            errs++;
            $display("FAIL err_reset got=%b want 0", addr_err_o);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("post_reset_quiet");
        end
        load_words(1'b0, 1'b0);
        mult_write(1'b0);
        pulse_done();
        read_random(S);
        check_idle("after_wait_reset_run");
    endtask

    task automatic test_reset_midread();
        load_words(1'b0, 1'b0);
        mult_write(1'b0);
        pulse_done();
        read_random(3);
        do_reset();
        check_idle("reset_midread");
        load_words(1'b0, 1'b0);
        verify_mem();
        mult_write(1'b0);
        pulse_done();
        read_random(S);
        check_idle("after_midread_run");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_done_in_load();
        test_addr_err();
        test_reset_wait();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
